vector_mem_sequencer: RTL and testbench
=======================================

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 Parameter WORD_W, default 32, data memory word width in bits.
REQ-002 Parameter VEC_BEATS, default 4, words per vector access; the vector width is WORD_W*VEC_BEATS (128).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 MemReqM  in  1  MEM-stage instruction performs a data access.
REQ-006 MemWriteM  in  1  1 = store, 0 = load.
REQ-007 VecM  in  1  1 = 128-bit vector access, 0 = 32-bit scalar access.
REQ-008 AddrM  in  32  byte address of the access.
REQ-009 WDataM  in  32  scalar store data.
REQ-010 WDataVM  in  128  vector store data; lane k is bits [32k+31:32k].
REQ-011 MemRData  in  32  data memory read word, combinational in MemAddr.
REQ-012 MemAddr  out  32  data memory word address, byte-addressed with bits [1:0] = 0.
REQ-013 MemWE  out  1  data memory write enable.
REQ-014 MemWData  out  32  data memory write word.
REQ-015 RDataM  out  32  scalar load result.
REQ-016 RDataVM  out  128  vector load result.
REQ-017 BusyDA  out  1  stall request to hazard_unit, which freezes F/D/E/M.
REQ-018 DoneDA  out  1  one-cycle pulse on the final cycle of any accepted access.
REQ-019 AlignErr  out  1  one-cycle pulse when an accepted vector access has AddrM[3:0] != 0.

Function
REQ-020 States: IDLE and BURST; 2-bit beat counter cnt.
REQ-021 Scalar access in IDLE shall complete in the same cycle with no stall:
- MemAddr = {AddrM[31:2],2'b00}; MemWE = MemWriteM; MemWData = WDataM; RDataM = MemRData.
- BusyDA = 0; DoneDA = 1.
REQ-022 Vector access in IDLE shall be accepted, issuing beat 0 combinationally from the inputs (address AddrM with bits [3:0] forced to 0; WDataVM lane 0).
REQ-023 On acceptance, the unit shall set BusyDA = 1, latch base address, MemWriteM and WDataVM, then move to BURST with cnt = 1.
REQ-024 In BURST, beat k = cnt shall use only latched values:
- MemAddr = base + 4k, modulo 2^32.
- MemWE = latched write flag; MemWData = latched lane k.
- Inputs changing mid-burst shall be ignored.
REQ-025 Load beats 0..VEC_BEATS-2 shall capture MemRData into lane buffer k at the clock edge.
REQ-026 On the final beat (cnt = 3), the unit shall drive:
- RDataVM = {MemRData, buf2, buf1, buf0}.
- BusyDA = 0; DoneDA = 1.
- Next state IDLE, cnt = 0.
REQ-027 Every vector access shall occupy exactly 4 cycles and assert BusyDA for exactly 3 consecutive cycles.
REQ-028 While in BURST, MemReqM shall not start a new access; a request present in the first IDLE cycle after completion shall be accepted normally (back-to-back).
REQ-029 MemReqM = 0 in IDLE shall force MemWE = 0, BusyDA = 0, DoneDA = 0 and AlignErr = 0.
REQ-030 RDataVM shall hold the last completed vector load value outside its final beat; RDataM is combinational pass-through.

Reset
REQ-031 Asserting rst at any time, mid-burst included, shall immediately force:
- state = IDLE, cnt = 0;
- base, write flag, lane buffers and stored vector data = 0;
- MemWE = 0, BusyDA = 0, DoneDA = 0, AlignErr = 0.
REQ-032 Any burst cut short by reset shall be abandoned and never resumed; the first cycle after release shall be normal IDLE.

Structure
REQ-033 A shared package mem_seq_pkg shall hold the state enum (IDLE, BURST), WORD_W, VEC_BEATS, VEC_W and the lane-select helper constants.
REQ-034 The block shall be flat except for one sub-module, vec_lane_buffer: a 3x32-bit capture register with write-enable and index.

Verification
REQ-035 Scalar load, AddrM=0x0000_0013, memory word@0x10=0xCAFEBABE -> MemAddr=0x10, RDataM=0xCAFEBABE, BusyDA=0, DoneDA=1 in the same cycle.
REQ-036 Vector load at 0x20, words 0x11111111,0x22222222,0x33333333,0x44444444 -> MemAddr 0x20,0x24,0x28,0x2C on cycles 0-3; BusyDA=1,1,1,0; RDataVM=0x44444444_33333333_22222222_11111111 with DoneDA on cycle 3.
REQ-037 Vector store at 0xFFFF_FFF0, WDataVM=0xA..D lanes, with WDataVM changed after cycle 0 -> writes of original lanes to 0xFFFFFFF0..0xFFFFFFFC, and no wrap beyond 0xFFFFFFFC.
REQ-038 Vector load at 0x2C -> AlignErr pulse on cycle 0, beats issued at 0x20..0x2C.
REQ-039 rst asserted during cnt=2 -> BusyDA and MemWE low without waiting for a clock edge; after release, a scalar store completes in 1 cycle.
REQ-040 Two back-to-back vector loads -> 8 cycles total, BusyDA pattern 1,1,1,0,1,1,1,0, two DoneDA pulses.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the vector data-memory sequencer.
// Beat and lane arithmetic helpers are kept here so the top and the lane buffer agree.
package mem_seq_pkg;

  localparam int WORD_W    = 32;
  localparam int VEC_BEATS = 4;
  localparam int VEC_W     = WORD_W * VEC_BEATS;

  // Beat counter width and byte-address bit positions used for lane selection.
  localparam int CNT_W          = 2;
  localparam int WORD_BYTE_BITS = 2;
  localparam int VEC_ALIGN_BITS = 4;
  localparam int BUF_LANES      = VEC_BEATS - 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } seqState_t;

endpackage

// File: rtl/vec_lane_buffer.sv
// Capture register for the leading lanes of a vector load; the final lane
// bypasses this buffer and comes straight from the memory read port.
module vec_lane_buffer
  import mem_seq_pkg::*;
#(
  parameter int LANE_W = WORD_W,
  parameter int LANES  = BUF_LANES,
  parameter int IDX_W  = CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [LANE_W-1:0]            wData,
  output logic [LANES-1:0][LANE_W-1:0] lanes
);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values. The lanes are reset (unlike a RAM) so an abandoned burst
  // can never leak stale data into a later result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (we && (idx == IDX_W'(i))) lanes[i] <= wData;
      end
    end
  end

endmodule

// File: rtl/vector_mem_sequencer.sv
// MEM-stage data access sequencer: scalar accesses complete in one cycle, vector
// accesses are split into one word beat per cycle while the pipeline is stalled.
module vector_mem_sequencer #(
  parameter int WORD_W    = mem_seq_pkg::WORD_W,
  parameter int VEC_BEATS = mem_seq_pkg::VEC_BEATS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          MemReqM,
  input  logic                          MemWriteM,
  input  logic                          VecM,
  input  logic [31:0]                   AddrM,
  input  logic [WORD_W-1:0]             WDataM,
  input  logic [WORD_W*VEC_BEATS-1:0]   WDataVM,
  input  logic [WORD_W-1:0]             MemRData,
  output logic [31:0]                   MemAddr,
  output logic                          MemWE,
  output logic [WORD_W-1:0]             MemWData,
  output logic [WORD_W-1:0]             RDataM,
  output logic [WORD_W*VEC_BEATS-1:0]   RDataVM,
  output logic                          BusyDA,
  output logic                          DoneDA,
  output logic                          AlignErr
);

  import mem_seq_pkg::*;

  localparam int LANES = VEC_BEATS - 1;

  seqState_t                          state, nextState;
  logic [CNT_W-1:0]                   cnt, nextCnt;
  logic [31:0]                        baseAddr;
  logic                               wrFlag;
  logic [VEC_BEATS-1:0][WORD_W-1:0]   wDataLat;
  logic [WORD_W*VEC_BEATS-1:0]        vecOut;
  logic [LANES-1:0][WORD_W-1:0]       lanes;

  logic             reqLive;
  logic             startVec;
  logic             lastBeat;
  logic             bufWe;
  logic [CNT_W-1:0] bufIdx;
  logic [31:0]      vecBase;

  // Reset also masks the request so no strobe can escape while rst is high.
  assign reqLive = MemReqM && !rst;
  assign vecBase = {AddrM[31:VEC_ALIGN_BITS], {VEC_ALIGN_BITS{1'b0}}};
  assign RDataM  = MemRData;

  // NOTE: every output and next-state value gets a default before the case, so
  // no path through this block can infer a latch.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    MemAddr   = {AddrM[31:WORD_BYTE_BITS], {WORD_BYTE_BITS{1'b0}}};
    MemWE     = 1'b0;
    MemWData  = WDataM;
    BusyDA    = 1'b0;
    DoneDA    = 1'b0;
    AlignErr  = 1'b0;
    startVec  = 1'b0;
    lastBeat  = 1'b0;
    bufWe     = 1'b0;
    bufIdx    = cnt;

    unique case (state)
      IDLE: begin
        if (reqLive && VecM) begin
          // Beat 0 is issued straight from the inputs while the rest are latched.
          MemAddr   = vecBase;
          MemWE     = MemWriteM;
          MemWData  = WDataVM[WORD_W-1:0];
          BusyDA    = 1'b1;
          AlignErr  = (AddrM[VEC_ALIGN_BITS-1:0] != '0);
          startVec  = 1'b1;
          bufWe     = !MemWriteM;
          bufIdx    = '0;
          nextState = BURST;
          nextCnt   = CNT_W'(1);
        end else if (reqLive) begin
          MemWE  = MemWriteM;
          DoneDA = 1'b1;
        end
      end
      BURST: begin
        MemAddr  = baseAddr + 32'({cnt, {WORD_BYTE_BITS{1'b0}}});
        MemWE    = wrFlag;
        MemWData = wDataLat[cnt];
        if (cnt == LAST_BEAT) begin
          DoneDA    = 1'b1;
          lastBeat  = 1'b1;
          nextState = IDLE;
          nextCnt   = '0;
        end else begin
          BusyDA  = 1'b1;
          bufWe   = !wrFlag;
          nextCnt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baseAddr <= '0;
      wrFlag   <= 1'b0;
      wDataLat <= '0;
      vecOut   <= '0;
    end else begin
      if (startVec) begin
        baseAddr <= vecBase;
        wrFlag   <= MemWriteM;
        wDataLat <= WDataVM;
      end
      if (lastBeat && !wrFlag) vecOut <= {MemRData, lanes};
    end
  end

  // The final lane is forwarded combinationally so the result appears on the done cycle.
  assign RDataVM = (lastBeat && !wrFlag) ? {MemRData, lanes} : vecOut;

  vec_lane_buffer #(
    .LANE_W (WORD_W),
    .LANES  (LANES),
    .IDX_W  (CNT_W)
  ) u_laneBuf (
    .clk   (clk),
    .rst   (rst),
    .we    (bufWe),
    .idx   (bufIdx),
    .wData (MemRData),
    .lanes (lanes)
  );

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench: the driver predicts each access from address/width rules and a
// shadow memory; a negedge monitor compares the beats and results the DUT presents.
module tb_vector_mem_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         MemReqM = 1'b0, MemWriteM = 1'b0, VecM = 1'b0;
  logic [31:0]  AddrM = '0, WDataM = '0;
  logic [127:0] WDataVM = '0;
  logic [31:0]  MemRData;
  logic [31:0]  MemAddr, MemWData, RDataM;
  logic         MemWE, BusyDA, DoneDA, AlignErr;
  logic [127:0] RDataVM;

  always #5 clk = ~clk;

  vector_mem_sequencer #(.WORD_W(32), .VEC_BEATS(4)) dut (
    .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemWriteM(MemWriteM), .VecM(VecM),
    .AddrM(AddrM), .WDataM(WDataM), .WDataVM(WDataVM), .MemRData(MemRData),
    .MemAddr(MemAddr), .MemWE(MemWE), .MemWData(MemWData), .RDataM(RDataM),
    .RDataVM(RDataVM), .BusyDA(BusyDA), .DoneDA(DoneDA), .AlignErr(AlignErr)
  );

  // Small aliased memory: word index taken from address bits [7:2].
  logic [31:0] mem [64];
  logic [31:0] refMem [64];
  assign MemRData = mem[MemAddr[7:2]];
  always @(posedge clk) if (MemWE) mem[MemAddr[7:2]] <= MemWData;

  typedef struct {
    bit                vec;
    bit                wr;
    int                nBeats;
    logic [3:0][31:0]  addr;
    logic [3:0][31:0]  wdata;
    logic [3:0]        align;
    logic [31:0]       rScalar;
    logic [127:0]      rVec;
  } exp_t;

  exp_t expQ[$];
  int   nTests = 0;
  int   nFail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [3:0][31:0] obsAddr, obsWd;
  logic [3:0]       obsWe, obsAe;
  int               nObs = 0;
  logic [127:0]     heldVec = '0;

  always @(negedge clk) begin
    if (rst) begin
      nObs    = 0;
      heldVec = '0;
    end else if (BusyDA || DoneDA) begin
      if (nObs < 4) begin
        obsAddr[nObs[1:0]] = MemAddr;
        obsWd[nObs[1:0]]   = MemWData;
        obsWe[nObs[1:0]]   = MemWE;
        obsAe[nObs[1:0]]   = AlignErr;
      end
      nObs++;
      if (DoneDA) begin
        check("pendingExp", 128'(expQ.size() != 0), 128'(1));
        if (expQ.size() != 0) begin
          exp_t e;
          e = expQ.pop_front();
          check("beatCount", 128'(nObs), 128'(e.nBeats));
          check("busyAtDone", 128'(BusyDA), 128'(0));
          for (int k = 0; k < e.nBeats && k < nObs && k < 4; k++) begin
            check($sformatf("addr%0d", k), 128'(obsAddr[k]), 128'(e.addr[k]));
            check($sformatf("we%0d", k), 128'(obsWe[k]), 128'(e.wr));
            check($sformatf("alignErr%0d", k), 128'(obsAe[k]), 128'(e.align[k]));
            if (e.wr) check($sformatf("wdata%0d", k), 128'(obsWd[k]), 128'(e.wdata[k]));
          end
          if (!e.wr && e.vec) begin
            check("rdataVec", RDataVM, e.rVec);
            heldVec = e.rVec;
          end else if (!e.wr) begin
            check("rdataScalar", 128'(RDataM), 128'(e.rScalar));
          end else if (e.vec) begin
            check("vecHoldOnStore", RDataVM, heldVec);
          end
        end
        nObs = 0;
      end
    end else begin
      check("idleWE", 128'(MemWE), 128'(0));
      check("idleAlign", 128'(AlignErr), 128'(0));
      check("idleVecHold", RDataVM, heldVec);
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic scramble(input bit reqOn);
    MemReqM   = reqOn ? 1'($urandom) : 1'b0;
    MemWriteM = 1'($urandom);
    VecM      = 1'($urandom);
    AddrM     = $urandom;
    WDataM    = $urandom;
    WDataVM   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle();
    @(posedge clk); #1;
    scramble(1'b0);
  endtask

  task automatic issue(input bit vec, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [127:0] wdv);
    exp_t         e;
    logic [31:0]  a;
    logic [127:0] loaded;
    loaded   = '0;
    e.vec    = vec;
    e.wr     = wr;
    e.nBeats = vec ? 4 : 1;
    e.addr   = '0;
    e.wdata  = '0;
    e.align  = {3'b000, vec && (addr[3:0] != 4'h0)};
    for (int k = 0; k < e.nBeats; k++) begin
      a = vec ? ((addr & 32'hFFFF_FFF0) + 32'(4 * k)) : (addr & 32'hFFFF_FFFC);
      e.addr[k]  = a;
      e.wdata[k] = vec ? wdv[32*k +: 32] : wd;
      if (wr) refMem[a[7:2]] = e.wdata[k];
      else    loaded[32*k +: 32] = refMem[a[7:2]];
    end
    e.rScalar = loaded[31:0];
    e.rVec    = loaded;
    expQ.push_back(e);
    @(posedge clk); #1;
    MemReqM = 1'b1; VecM = vec; MemWriteM = wr; AddrM = addr; WDataM = wd; WDataVM = wdv;
    if (vec) begin
      repeat (3) begin
        @(posedge clk); #1;
        scramble(1'b1);
      end
    end
  endtask

  initial begin
    logic [127:0] rv;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = $urandom;
      refMem[i] = mem[i];
    end
    mem[4] = 32'hCAFEBABE;  refMem[4] = 32'hCAFEBABE;
    mem[8]  = 32'h11111111; refMem[8]  = 32'h11111111;
    mem[9]  = 32'h22222222; refMem[9]  = 32'h22222222;
    mem[10] = 32'h33333333; refMem[10] = 32'h33333333;
    mem[11] = 32'h44444444; refMem[11] = 32'h44444444;

    // Reset with a live vector store request on the inputs.
    MemReqM = 1'b1; VecM = 1'b1; MemWriteM = 1'b1; AddrM = 32'h2C;
    #12;
    check("rstBusy", 128'(BusyDA), 128'(0));
    check("rstWE", 128'(MemWE), 128'(0));
    check("rstDone", 128'(DoneDA), 128'(0));
    check("rstAlign", 128'(AlignErr), 128'(0));
    check("rstVec", RDataVM, 128'(0));
    @(posedge clk); #3;
    rst = 1'b0; MemReqM = 1'b0;

    issue(1'b0, 1'b0, 32'h0000_0013, '0, '0);
    issue(1'b1, 1'b0, 32'h0000_0020, '0, '0);
    issue(1'b1, 1'b1, 32'hFFFF_FFF0, '0,
          {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA});
    idle();
    issue(1'b1, 1'b0, 32'h0000_002C, '0, '0);
    idle();

    // Reset during the cnt=2 beat of a vector store: first two beats already committed.
    rv = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    MemReqM = 1'b1; VecM = 1'b1; MemWriteM = 1'b1; AddrM = 32'h40; WDataVM = rv;
    refMem[16] = rv[31:0];
    refMem[17] = rv[63:32];
    repeat (2) begin
      @(posedge clk); #1;
      scramble(1'b1);
    end
    #2;
    rst = 1'b1; MemReqM = 1'b1; VecM = 1'b1; MemWriteM = 1'b1;
    #1;
    check("midRstBusy", 128'(BusyDA), 128'(0));
    check("midRstWE", 128'(MemWE), 128'(0));
    check("midRstDone", 128'(DoneDA), 128'(0));
    check("midRstVec", RDataVM, 128'(0));
    @(posedge clk); #3;
    rst = 1'b0; MemReqM = 1'b0;
    issue(1'b0, 1'b1, 32'h0000_0044, 32'h5EED_F00D, '0);
    issue(1'b0, 1'b0, 32'h0000_0046, '0, '0);

    // Back-to-back vector loads.
    issue(1'b1, 1'b0, 32'h0000_0040, '0, '0);
    issue(1'b1, 1'b0, 32'h0000_0080, '0, '0);

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) idle();
      issue(1'($urandom), 1'($urandom), $urandom, $urandom,
            {$urandom, $urandom, $urandom, $urandom});
    end
    idle();

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    check("drainQueue", 128'(expQ.size()), 128'(0));
    repeat (2) idle();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
